// File: rtl/mcu_spi_selector.sv
// mcu_spi_selector: picks one of NUM_SRC MCU SPI sources and routes it to the
// misterynano MCU interface, switching only between transactions.
//
// Ports:
//   clk32        32 MHz system clock
//   por          synchronous active-high reset
//   src_sclk     per-source SPI clock (not registered)
//   src_csn      per-source chip select, active-low, asynchronous to clk32
//   src_mosi     per-source data toward the FPGA (not registered)
//   mcu_sclk     selected SPI clock
//   mcu_csn      selected chip select, held high while switching
//   mcu_mosi     selected data
//   src_miso_oe  registered MISO/INTn output enables toward the sources
//   active_src   registered index of the selected source
//   switching    high while the selector waits for the new source to go idle
//   switch_pulse one-cycle pulse on each change of active_src
module mcu_spi_selector #(
    parameter int unsigned NUM_SRC      = 2,
    parameter int unsigned DEFAULT_SRC  = 0,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE     = 4,
    parameter int unsigned REVERT_EN    = 0,
    parameter int unsigned IDLE_TIMEOUT = 32000000,
    parameter int unsigned FANOUT_ALL   = 1
) (
    input  logic                       clk32,
    input  logic                       por,
    input  logic [NUM_SRC-1:0]         src_sclk,
    input  logic [NUM_SRC-1:0]         src_csn,
    input  logic [NUM_SRC-1:0]         src_mosi,
    output logic                       mcu_sclk,
    output logic                       mcu_csn,
    output logic                       mcu_mosi,
    output logic [NUM_SRC-1:0]         src_miso_oe,
    output logic [$clog2(NUM_SRC)-1:0] active_src,
    output logic                       switching,
    output logic                       switch_pulse
);

    localparam int unsigned AW = $clog2(NUM_SRC);
    localparam int unsigned CW = $clog2(DEBOUNCE + 1);
    localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [NUM_SRC-1:0] OE_RST = (FANOUT_ALL != 0) ? {NUM_SRC{1'b1}}
                                          : (NUM_SRC'(1) << DEFAULT_SRC);

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_SWITCH = 1'b1
    } state_e;

    state_e                      state_q, state_d;
    logic [AW-1:0]               active_q, active_d;
    logic [NUM_SRC-1:0]          oe_q, oe_d;
    logic                        pulse_q, pulse_d;
    logic [NUM_SRC-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]               idle_q, idle_d;
    logic [NUM_SRC-1:0]          sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0]          csn_s;
    logic                        cand_found;
    logic [AW-1:0]               cand_idx;
    logic                        act_idle;

    // chip-select synchronizers; sclk/mosi stay raw for the pass-through
    always_ff @(posedge clk32) begin
        if (por) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '1;
        end else begin
            sync_q[0] <= src_csn;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign csn_s = sync_q[SYNC_STAGES-1];

    // state and registered outputs
    always_ff @(posedge clk32) begin
        if (por) begin
            state_q  <= ST_ACTIVE;
            active_q <= AW'(DEFAULT_SRC);
            oe_q     <= OE_RST;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
            idle_q   <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            oe_q     <= oe_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
            idle_q   <= idle_d;
        end
    end

    // next-state: candidate search, switch/revert decision, debounce and idle counting
    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        pulse_d    = 1'b0;
        cnt_d      = cnt_q;
        idle_d     = idle_q;
        cand_found = 1'b0;
        cand_idx   = '0;
        act_idle   = csn_s[active_q];

        // lowest-index source whose debounce counter has saturated
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!cand_found && (AW'(i) != active_q) && (cnt_q[i] == CW'(DEBOUNCE))) begin
                cand_found = 1'b1;
                cand_idx   = AW'(i);
            end
        end

        case (state_q)
            ST_ACTIVE: begin
                if (cand_found && act_idle) begin
                    active_d = cand_idx;
                    pulse_d  = 1'b1;
                    state_d  = ST_SWITCH;
                    cnt_d    = '0;
                    idle_d   = '0;
                end else if ((REVERT_EN != 0) && (active_q != AW'(DEFAULT_SRC)) && act_idle
                             && (idle_q == IW'(IDLE_TIMEOUT))) begin
                    active_d = AW'(DEFAULT_SRC);
                    pulse_d  = 1'b1;
                    state_d  = ST_SWITCH;
                    cnt_d    = '0;
                    idle_d   = '0;
                end else begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if ((AW'(i) == active_q) || csn_s[i]) begin
                            cnt_d[i] = '0;
                        end else if (cnt_q[i] != CW'(DEBOUNCE)) begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                    if ((REVERT_EN != 0) && (active_q != AW'(DEFAULT_SRC)) && act_idle) begin
                        idle_d = idle_q + 1'b1;
                    end else begin
                        idle_d = '0;
                    end
                end
            end
            ST_SWITCH: begin
                // wait out any transaction already running on the new source
                cnt_d  = '0;
                idle_d = '0;
                if (act_idle) state_d = ST_ACTIVE;
            end
            default: state_d = ST_ACTIVE;
        endcase

        oe_d = '1;
        if (FANOUT_ALL == 0) begin
            oe_d           = '0;
            oe_d[active_d] = 1'b1;
        end
    end

    assign mcu_sclk     = src_sclk[active_q];
    assign mcu_mosi     = src_mosi[active_q];
    assign mcu_csn      = (state_q == ST_SWITCH) ? 1'b1 : src_csn[active_q];
    assign src_miso_oe  = oe_q;
    assign active_src   = active_q;
    assign switching    = (state_q == ST_SWITCH);
    assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_mcu_spi_selector.sv
// Bench for mcu_spi_selector: directed scenarios followed by random chip-select
// traffic, every cycle compared against a behavioural model of the selector.
module tb_mcu_spi_selector;

    localparam int unsigned NS   = 4;
    localparam int unsigned DEF  = 0;
    localparam int unsigned SY   = 2;
    localparam int unsigned DEB  = 4;
    localparam int unsigned REV  = 1;
    localparam int unsigned IDLE = 100;
    localparam int unsigned FAN  = 0;

    logic          clk32 = 1'b0;
    logic          por;
    logic [NS-1:0] src_sclk, src_csn, src_mosi;
    logic          mcu_sclk, mcu_csn, mcu_mosi;
    logic [NS-1:0] src_miso_oe;
    logic [1:0]    active_src;
    logic          switching, switch_pulse;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    logic [NS-1:0] m_sync [SY];
    int            m_low  [NS];
    int            m_idle;
    int            m_act;
    bit            m_sw;
    bit            m_pulse;

    mcu_spi_selector #(
        .NUM_SRC(NS), .DEFAULT_SRC(DEF), .SYNC_STAGES(SY), .DEBOUNCE(DEB),
        .REVERT_EN(REV), .IDLE_TIMEOUT(IDLE), .FANOUT_ALL(FAN)
    ) dut (
        .clk32(clk32), .por(por),
        .src_sclk(src_sclk), .src_csn(src_csn), .src_mosi(src_mosi),
        .mcu_sclk(mcu_sclk), .mcu_csn(mcu_csn), .mcu_mosi(mcu_mosi),
        .src_miso_oe(src_miso_oe), .active_src(active_src),
        .switching(switching), .switch_pulse(switch_pulse)
    );

    always #5 clk32 = ~clk32;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // select a new source: every debounce run and the idle time restart
    task automatic model_select(input int src);
        m_act   = src;
        m_pulse = 1'b1;
        m_sw    = 1'b1;
        m_idle  = 0;
        for (int i = 0; i < NS; i++) m_low[i] = 0;
    endtask

    // one clock: advance the model on the rising edge, compare on the falling edge
    task automatic step();
        logic [NS-1:0] seen;
        int            cand;
        @(posedge clk32);
        if (por) begin
            for (int s = 0; s < SY; s++) m_sync[s] = '1;
            for (int i = 0; i < NS; i++) m_low[i] = 0;
            m_idle  = 0;
            m_act   = DEF;
            m_sw    = 1'b0;
            m_pulse = 1'b0;
        end else begin
            seen = m_sync[SY-1];
            for (int s = SY - 1; s > 0; s--) m_sync[s] = m_sync[s-1];
            m_sync[0] = src_csn;
            m_pulse   = 1'b0;
            if (m_sw) begin
                for (int i = 0; i < NS; i++) m_low[i] = 0;
                m_idle = 0;
                if (seen[m_act]) m_sw = 1'b0;
            end else begin
                cand = -1;
                for (int i = 0; i < NS; i++)
                    if (cand < 0 && i != m_act && m_low[i] >= DEB) cand = i;
                if (cand >= 0 && seen[m_act]) begin
                    model_select(cand);
                end else if (REV != 0 && m_act != DEF && seen[m_act] && m_idle >= IDLE) begin
                    model_select(DEF);
                end else begin
                    for (int i = 0; i < NS; i++)
                        m_low[i] = (i == m_act || seen[i]) ? 0 : ((m_low[i] < DEB) ? m_low[i] + 1 : DEB);
                    m_idle = (m_act != DEF && seen[m_act]) ? m_idle + 1 : 0;
                end
            end
        end
        @(negedge clk32);
        chk("active_src", 32'(active_src), 32'(m_act));
        chk("switching", 32'(switching), 32'(m_sw));
        chk("switch_pulse", 32'(switch_pulse), 32'(m_pulse));
        chk("miso_oe", 32'(src_miso_oe), 32'(1) << m_act);
        chk("mcu_csn", 32'(mcu_csn), m_sw ? 32'd1 : 32'(src_csn[m_act]));
        chk("mcu_sclk", 32'(mcu_sclk), 32'(src_sclk[m_act]));
        chk("mcu_mosi", 32'(mcu_mosi), 32'(src_mosi[m_act]));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        por      = 1'b1;
        src_csn  = '1;
        src_sclk = '0;
        src_mosi = '0;
        for (int s = 0; s < SY; s++) m_sync[s] = '1;
        for (int i = 0; i < NS; i++) m_low[i] = 0;
        m_idle = 0; m_act = DEF; m_sw = 1'b0; m_pulse = 1'b0;

        // reset state
        run(3);
        chk("rst_active", 32'(active_src), 32'd0);
        chk("rst_switching", 32'(switching), 32'd0);
        chk("rst_pulse", 32'(switch_pulse), 32'd0);
        chk("rst_oe", 32'(src_miso_oe), 32'h1);
        chk("rst_mcu_csn", 32'(mcu_csn), 32'd1);
        por = 1'b0;
        run(2);

        // source 1 takes over 6 cycles after its csn falls, then reverts after 100 idle cycles
        src_csn[1] = 1'b0;
        run(6);
        chk("t1_not_yet", 32'(active_src), 32'd0);
        run(1);
        chk("t1_switched", 32'(active_src), 32'd1);
        chk("t1_pulse", 32'(switch_pulse), 32'd1);
        chk("t1_switching", 32'(switching), 32'd1);
        chk("t1_csn_held", 32'(mcu_csn), 32'd1);
        run(3);
        chk("t1_pulse_once", 32'(switch_pulse), 32'd0);
        chk("t1_csn_still_held", 32'(mcu_csn), 32'd1);
        src_csn[1] = 1'b1;
        run(2);
        chk("t1_switch_hold", 32'(switching), 32'd1);
        run(1);
        chk("t1_switch_exit", 32'(switching), 32'd0);
        run(100);
        chk("t1_pre_revert", 32'(active_src), 32'd1);
        run(1);
        chk("t1_revert", 32'(active_src), 32'd0);
        chk("t1_revert_pulse", 32'(switch_pulse), 32'd1);
        run(3);

        // short csn glitches are rejected and leave no residue
        for (int g = 0; g < 2; g++) begin
            src_csn[1] = 1'b0;
            run(3);
            src_csn[1] = 1'b1;
            run(6);
            chk("t2_glitch", 32'(active_src), 32'd0);
        end

        // activity on the selected source at idle count 99 restarts the revert timer
        src_csn[1] = 1'b0;
        run(10);
        src_csn[1] = 1'b1;
        run(3);
        run(97);
        src_csn[1] = 1'b0;
        run(1);
        chk("t3_csn_follow", 32'(mcu_csn), 32'd0);
        src_csn[1] = 1'b1;
        run(3);
        chk("t3_no_revert", 32'(active_src), 32'd1);
        run(100);
        chk("t3_late_revert", 32'(active_src), 32'd0);
        chk("t3_late_pulse", 32'(switch_pulse), 32'd1);
        run(3);

        // busy default source: switch only once its transaction ends
        src_csn[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            src_sclk[0] = ~src_sclk[0];
            src_mosi[0] = 1'($urandom);
            step();
        end
        src_csn[1] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            src_sclk[0] = ~src_sclk[0];
            src_mosi[0] = 1'($urandom);
            step();
        end
        chk("t4_busy_hold", 32'(active_src), 32'd0);
        src_csn[0] = 1'b1;
        run(2);
        chk("t4_still_0", 32'(active_src), 32'd0);
        run(1);
        chk("t4_switched", 32'(active_src), 32'd1);
        src_csn[1] = 1'b1;
        run(4);
        chk("t4_active", 32'(switching), 32'd0);

        // simultaneous candidates: lowest index wins
        src_csn[2] = 1'b0;
        src_csn[3] = 1'b0;
        run(6);
        chk("t5_not_yet", 32'(active_src), 32'd1);
        run(1);
        chk("t5_lowest", 32'(active_src), 32'd2);
        chk("t5_switching", 32'(switching), 32'd1);

        // reset while switching
        por = 1'b1;
        run(1);
        chk("t6_active", 32'(active_src), 32'd0);
        chk("t6_switching", 32'(switching), 32'd0);
        chk("t6_pulse", 32'(switch_pulse), 32'd0);
        chk("t6_mcu_csn", 32'(mcu_csn), 32'(src_csn[0]));
        src_csn[2] = 1'b1;
        src_csn[3] = 1'b1;
        por = 1'b0;
        run(3);

        // random traffic
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < NS; i++)
                if ($urandom_range(5) == 0) src_csn[i] = ~src_csn[i];
            src_sclk = NS'($urandom);
            src_mosi = NS'($urandom);
            por      = ($urandom_range(999) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
